mmc3_scanline_irq: RTL and testbench



---
 rtl/mmc3_pkg.sv | 15 +
 rtl/mmc3_a12_filter.sv | 41 ++++
 rtl/mmc3_scanline_irq.sv | 109 ++++++++++
 tb/tb_mmc3_scanline_irq.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/mmc3_pkg.sv
// Shared encodings for the MMC3 scanline IRQ block: register-write targets and
// counter semantics selection.
package mmc3_pkg;

  typedef enum logic [1:0] {
    SEL_LATCH   = 2'd0,
    SEL_RELOAD  = 2'd1,
    SEL_DISABLE = 2'd2,
    SEL_ENABLE  = 2'd3
  } wr_sel_e;

  localparam int MODE_SHARP = 0;
  localparam int MODE_NEC   = 1;

endpackage

// File: rtl/mmc3_a12_filter.sv
// Synchronises raw PPU A12 onto m2 and emits a single-cycle tick on a rise that
// follows at least A12_FILTER consecutive low samples.
module mmc3_a12_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int A12_FILTER  = 3
) (
  input  logic m2,
  input  logic rst_n,
  input  logic ppu_a12,
  output logic tick
);

  localparam int LW = $clog2(A12_FILTER + 1);
  localparam logic [LW-1:0] LOW_MAX = LW'(A12_FILTER);

  logic [SYNC_STAGES-1:0] sync;
  logic                   a12_s;
  logic                   a12_q;
  logic [LW-1:0]          low_cnt;

  assign a12_s = sync[SYNC_STAGES-1];

  always_ff @(posedge m2 or negedge rst_n) begin
    if (!rst_n) begin
      sync    <= '0;
      a12_q   <= 1'b0;
      low_cnt <= '0;
    end else begin
      sync  <= {sync[SYNC_STAGES-2:0], ppu_a12};
      a12_q <= a12_s;
      if (a12_s)
        low_cnt <= '0;
      else if (low_cnt != LOW_MAX)
        low_cnt <= low_cnt + LW'(1);
    end
  end

  // low_cnt still holds the pre-rise low run during the rising cycle
  assign tick = a12_s & ~a12_q & (low_cnt == LOW_MAX);

endmodule

// File: rtl/mmc3_scanline_irq.sv
// MMC3 scanline IRQ counter on m2: reloadable down-counter driven by filtered
// A12 rises, Sharp or NEC semantics. Optional status port: MMC3_IRQ_STATUS_EN.
module mmc3_scanline_irq
  import mmc3_pkg::*;
#(
  parameter int CNT_W       = 8,
  parameter int A12_FILTER  = 3,
  parameter int SYNC_STAGES = 2,
  parameter int IRQ_MODE    = MODE_SHARP
) (
  input  logic             m2,
  input  logic             rst_n,
  input  logic             ppu_a12,
  input  logic             wr_en,
  input  logic [1:0]       wr_sel,
  input  logic [CNT_W-1:0] wr_data,
  output logic             irq_pending,
  output wire              irq
`ifdef MMC3_IRQ_STATUS_EN
  ,
  input  logic             rd_ack,
  output logic [CNT_W-1:0] cnt_val,
  output logic             reload_pend
`endif
);

  logic             tick;
  logic [CNT_W-1:0] counter;
  logic [CNT_W-1:0] latch;
  logic [CNT_W-1:0] cnt_next;
  logic             reload_flag;
  logic             enabled;
  logic             do_reload;
  logic             fire;
  logic             ack;
  logic             wr_latch, wr_reload, wr_disable, wr_enable;

  mmc3_a12_filter #(
    .SYNC_STAGES(SYNC_STAGES),
    .A12_FILTER (A12_FILTER)
  ) u_filter (
    .m2     (m2),
    .rst_n  (rst_n),
    .ppu_a12(ppu_a12),
    .tick   (tick)
  );

  assign wr_latch   = wr_en && (wr_sel == SEL_LATCH);
  assign wr_reload  = wr_en && (wr_sel == SEL_RELOAD);
  assign wr_disable = wr_en && (wr_sel == SEL_DISABLE);
  assign wr_enable  = wr_en && (wr_sel == SEL_ENABLE);

`ifdef MMC3_IRQ_STATUS_EN
  assign ack         = rd_ack;
  assign cnt_val     = counter;
  assign reload_pend = reload_flag;
`else
  assign ack = 1'b0;
`endif

  always_comb begin
    // a reload write landing on a tick is folded into that tick's reload
    do_reload = reload_flag || (counter == '0) || wr_reload;
    cnt_next  = do_reload ? latch : counter - CNT_W'(1);
    fire      = 1'b0;
    if (enabled && (cnt_next == '0)) begin
      if (IRQ_MODE == MODE_SHARP)
        fire = 1'b1;
      else
        fire = (counter != '0) || (do_reload && (latch != '0));
    end
  end

  always_ff @(posedge m2 or negedge rst_n) begin
    if (!rst_n) begin
      counter     <= '0;
      latch       <= '0;
      reload_flag <= 1'b0;
      enabled     <= 1'b0;
      irq_pending <= 1'b0;
    end else begin
      if (wr_latch)
        latch <= wr_data;

      if (tick) begin
        counter     <= cnt_next;
        reload_flag <= 1'b0;
      end else if (wr_reload) begin
        counter     <= '0;
        reload_flag <= 1'b1;
      end

      if (wr_disable)
        enabled <= 1'b0;
      else if (wr_enable)
        enabled <= 1'b1;

      if (wr_disable)
        irq_pending <= 1'b0;
      else if (tick && fire)
        irq_pending <= 1'b1;
      else if (ack)
        irq_pending <= 1'b0;
    end
  end

  assign irq = irq_pending ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_mmc3_scanline_irq.sv
// Directed bench: Sharp and NEC instances share stimulus; irq lines are pulled
// up so a released (high-Z) irq reads as 1.
module tb_mmc3_scanline_irq;

  logic       m2;
  logic       rst_n;
  logic       ppu_a12;
  logic       wr_en;
  logic [1:0] wr_sel;
  logic [7:0] wr_data;
  logic       pend_s, pend_n;
  wire        irq_s, irq_n;
  int         n_tests = 0;
  int         n_fail  = 0;
`ifdef MMC3_IRQ_STATUS_EN
  logic       rd_ack;
  logic [7:0] cnt_s, cnt_n;
  logic       rp_s, rp_n;
`endif

  pullup (irq_s);
  pullup (irq_n);

  mmc3_scanline_irq #(.CNT_W(8), .A12_FILTER(3), .SYNC_STAGES(2), .IRQ_MODE(0)) dut (
    .m2(m2), .rst_n(rst_n), .ppu_a12(ppu_a12), .wr_en(wr_en), .wr_sel(wr_sel),
    .wr_data(wr_data), .irq_pending(pend_s), .irq(irq_s)
`ifdef MMC3_IRQ_STATUS_EN
    , .rd_ack(rd_ack), .cnt_val(cnt_s), .reload_pend(rp_s)
`endif
  );

  mmc3_scanline_irq #(.CNT_W(8), .A12_FILTER(3), .SYNC_STAGES(2), .IRQ_MODE(1)) dut_nec (
    .m2(m2), .rst_n(rst_n), .ppu_a12(ppu_a12), .wr_en(wr_en), .wr_sel(wr_sel),
    .wr_data(wr_data), .irq_pending(pend_n), .irq(irq_n)
`ifdef MMC3_IRQ_STATUS_EN
    , .rd_ack(rd_ack), .cnt_val(cnt_n), .reload_pend(rp_n)
`endif
  );

  initial m2 = 1'b0;
  always #5 m2 = ~m2;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    n_tests++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge m2);
      #1;
    end
  endtask

  task automatic wr(input logic [1:0] sel, input logic [7:0] data);
    wr_en = 1'b1; wr_sel = sel; wr_data = data;
    cyc(1);
    wr_en = 1'b0; wr_data = 8'h00;
  endtask

  // 4 low cycles, then rise; the tick lands on the 3rd edge after the rise
  task automatic a12_tick();
    ppu_a12 = 1'b0; cyc(4);
    ppu_a12 = 1'b1; cyc(3);
  endtask

  // same, but the write is presented on the edge where the tick is applied
  task automatic a12_tick_wr(input logic [1:0] sel, input logic [7:0] data);
    ppu_a12 = 1'b0; cyc(4);
    ppu_a12 = 1'b1; cyc(2);
    wr(sel, data);
  endtask

  task automatic ack_all();
    wr(2'd2, 8'h00);
    wr(2'd3, 8'h00);
  endtask

  initial begin
    rst_n = 1'b0; ppu_a12 = 1'b0; wr_en = 1'b0; wr_sel = 2'd0; wr_data = 8'h00;
`ifdef MMC3_IRQ_STATUS_EN
    rd_ack = 1'b0;
`endif
    cyc(3);
    chk("rst_pend", {15'd0, pend_s}, 16'd0);
    chk("rst_irq", {15'd0, irq_s}, 16'd1);
    rst_n = 1'b1;
    cyc(2);
    chk("rst_cnt", {8'd0, dut.counter}, 16'd0);

    // 1: latch 3, reload, enable, four ticks
    wr(2'd0, 8'd3); wr(2'd1, 8'd0); wr(2'd3, 8'd0);
    a12_tick(); chk("t1_cnt3", {8'd0, dut.counter}, 16'd3);
    a12_tick(); chk("t1_cnt2", {8'd0, dut.counter}, 16'd2);
    a12_tick(); chk("t1_cnt1", {8'd0, dut.counter}, 16'd1);
    chk("t1_nopend", {15'd0, pend_s}, 16'd0);
    ppu_a12 = 1'b0; cyc(4);
    ppu_a12 = 1'b1; cyc(2);
    chk("t1_lat_pend", {15'd0, pend_s}, 16'd0);
    chk("t1_lat_cnt", {8'd0, dut.counter}, 16'd1);
    cyc(1);
    chk("t1_cnt0", {8'd0, dut.counter}, 16'd0);
    chk("t1_pend", {15'd0, pend_s}, 16'd1);
    chk("t1_irq", {15'd0, irq_s}, 16'd0);
    chk("t1_nec_pend", {15'd0, pend_n}, 16'd1);
`ifdef MMC3_IRQ_STATUS_EN
    chk("st_cnt", {8'd0, cnt_s}, 16'd0);
    chk("st_rp", {15'd0, rp_s}, 16'd0);
    rd_ack = 1'b1; cyc(1); rd_ack = 1'b0;
    chk("st_ack_pend", {15'd0, pend_s}, 16'd0);
    chk("st_ack_en", {15'd0, dut.enabled}, 16'd1);
`endif

    // 2: glitch filter
    ack_all();
    ppu_a12 = 1'b0; cyc(2);
    ppu_a12 = 1'b1; cyc(4);
    chk("t2_glitch", {8'd0, dut.counter}, 16'd0);
    ppu_a12 = 1'b0; cyc(3);
    ppu_a12 = 1'b1; cyc(3);
    chk("t2_tick", {8'd0, dut.counter}, 16'd3);
    chk("t2_nopend", {15'd0, pend_s}, 16'd0);

    // 3: latch 0 behaviour
    wr(2'd0, 8'd0); wr(2'd1, 8'd0);
    a12_tick();
    chk("t3_cnt", {8'd0, dut.counter}, 16'd0);
    chk("t3_sharp1", {15'd0, pend_s}, 16'd1);
    chk("t3_nec1", {15'd0, pend_n}, 16'd0);
    ack_all();
    a12_tick();
    chk("t3_sharp2", {15'd0, pend_s}, 16'd1);
    chk("t3_nec2", {15'd0, pend_n}, 16'd0);

    // 4: disable coincident with the firing tick
    ack_all();
    wr(2'd0, 8'd1); wr(2'd1, 8'd0);
    a12_tick();
    chk("t4_cnt1", {8'd0, dut.counter}, 16'd1);
    a12_tick_wr(2'd2, 8'd0);
    chk("t4_cnt0", {8'd0, dut.counter}, 16'd0);
    chk("t4_pend", {15'd0, pend_s}, 16'd0);
    chk("t4_irq", {15'd0, irq_s}, 16'd1);
    chk("t4_nec_pend", {15'd0, pend_n}, 16'd0);
    wr(2'd3, 8'd0);
    chk("t4_en_pend", {15'd0, pend_s}, 16'd0);
    chk("t4_en_irq", {15'd0, irq_s}, 16'd1);

    // 5: reload write coincident with tick (counter 5, latch 9)
    wr(2'd0, 8'd5); wr(2'd1, 8'd0);
    a12_tick();
    chk("t5_cnt5", {8'd0, dut.counter}, 16'd5);
    wr(2'd0, 8'd9);
    a12_tick_wr(2'd1, 8'd0);
    chk("t5_cnt9", {8'd0, dut.counter}, 16'd9);
    chk("t5_flag", {15'd0, dut.reload_flag}, 16'd0);
    chk("t5_pend", {15'd0, pend_s}, 16'd0);
    // latch write coincident with a reloading tick uses the old latch
    wr(2'd1, 8'd0);
    a12_tick_wr(2'd0, 8'd7);
    chk("t5_oldlatch", {8'd0, dut.counter}, 16'd9);
    chk("t5_newlatch", {8'd0, dut.latch}, 16'd7);

    // 6: async reset mid-count with counter 2, pending 1
    wr(2'd0, 8'd1); wr(2'd1, 8'd0);
    a12_tick(); a12_tick();
    chk("t6_pend_pre", {15'd0, pend_s}, 16'd1);
    wr(2'd0, 8'd3);
    a12_tick(); a12_tick();
    chk("t6_cnt_pre", {8'd0, dut.counter}, 16'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_cnt", {8'd0, dut.counter}, 16'd0);
    chk("t6_latch", {8'd0, dut.latch}, 16'd0);
    chk("t6_en", {15'd0, dut.enabled}, 16'd0);
    chk("t6_pend", {15'd0, pend_s}, 16'd0);
    chk("t6_irq", {15'd0, irq_s}, 16'd1);
    chk("t6_nec_irq", {15'd0, irq_n}, 16'd1);
    cyc(2);
    rst_n = 1'b1;
    // A12 is still high: its arrival after reset must not count as a rise
    wr(2'd0, 8'd5);
    cyc(4);
    chk("t6_norise", {8'd0, dut.counter}, 16'd0);
    a12_tick();
    chk("t6_first", {8'd0, dut.counter}, 16'd5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
